aes_round_seq: RTL and testbench
================================

# aes_round_seq

Parametrised AES round sequencer: next generation of the fixed AES-128 round-constant and one-hot round-counter pair. Supports AES-128/192/256, forward (encrypt) and reverse (decrypt) round order, and a start/advance/done handshake with the datapath. Sits between the cipher control FSM and the round datapath and key expander. Emits round index, first/final flags and the round constant for the current round.

## Interface
- SUPPORT_192, default 1: accept key_len=1 (Nr=12); 0 = reject.
- SUPPORT_256, default 1: accept key_len=2 (Nr=14); 0 = reject.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new block run; sampled only in IDLE.
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled with start.
- decrypt  in  1  0=forward rounds 0..Nr, 1=reverse rounds Nr..0; sampled with start.
- adv  in  1  datapath finished current round; sampled only in RUN.
- busy  out  1  high in RUN.
- rnd_idx  out  4  current round-key index r.
- first_rnd  out  1  high on the first step of a run (r=0 encrypt, r=Nr decrypt).
- final_rnd  out  1  high on the last step (r=Nr encrypt, r=0 decrypt).
- rcon  out  8  x^(r-1) in GF(2^8) mod 0x11b; 0x00 when r=0.
- done  out  1  one-cycle pulse after the final step is accepted.
- err  out  1  one-cycle pulse when start is rejected (illegal/unsupported key_len).

## Operation
- States: IDLE, RUN. All state and outputs registered.
- Reset (synchronous, active-high): state=IDLE; rnd_idx=0, rcon=0x00, first_rnd=0, final_rnd=0, busy=0, done=0, err=0. Reset mid-run abandons the run, no done.
- IDLE + start + legal key_len: latch Nr (10/12/14) and decrypt; go RUN. Encrypt: r=0, rcon=0x00. Decrypt: r=Nr, rcon=0x36/0xd8/0x4d for Nr=10/12/14.
- IDLE + start + illegal key_len (3, or 1/2 with matching SUPPORT_* = 0): stay IDLE, err=1 next cycle.
- RUN + adv, not final: encrypt r→r+1, rcon = (r==0) ? 0x01 : xtime(rcon). Decrypt r→r−1, rcon = (r==1) ? 0x00 : inv_xtime(rcon).
- xtime(a) = (a<<1) ^ (a[7] ? 0x1b : 0); inv_xtime(a) = a[0] ? ((a^0x1b)>>1)|0x80 : a>>1.
- RUN + adv on final step: go IDLE, outputs to reset values, done=1 for one cycle.
- RUN + no adv: all outputs hold (stall, unbounded).
- start while RUN: ignored, no err. adv in IDLE: ignored. start and adv together in IDLE: start acts, adv ignored.
- first_rnd and final_rnd are derived from r, direction and Nr, never both high.

## Timing
- start accepted at edge N → busy, first_rnd and step values valid from N+1.
- One step per adv-high cycle; back-to-back adv gives one round per cycle.
- Minimum run: Nr+1 adv cycles. done at cycle after final adv; busy low in the same cycle.
- New start accepted in the done cycle (state is already IDLE).
- err valid cycle after rejected start.

## Structure
- Shared package aes_pkg: key_len encodings, NR_128/192/256 constants, RCON_DEC_START_* constants, xtime and inv_xtime functions, state enum.
- One sub-module, rcon_step: combinational bidirectional GF(2^8) ×x / ×x^-1 with r==0/r==1 zeroing, reused by the key expander.

## Test plan
- Encrypt AES-128, adv every cycle → rcon 00,01,02,04,08,10,20,40,80,1b,36; first_rnd at r=0; final_rnd at r=10; done one cycle after 11th adv.
- Decrypt AES-256, adv every cycle → r 14..0; rcon 4d,ab,d8,6c,36,1b,80,…,01,00; final_rnd at r=0.
- Encrypt AES-192 with adv toggling 1/0 → outputs hold on adv=0 cycles; 13 steps, last rcon 0xd8 at r=12.
- key_len=3, and key_len=2 with SUPPORT_256=0 → err pulse, busy stays 0; start during RUN → no effect.
- rst at r=5 mid-run → next cycle all outputs at reset values, no done; immediate new start runs normally.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-length encodings, round counts and GF(2^8) step helpers
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;
  localparam logic [1:0] KEY_LEN_ILL = 2'd3;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // x^(Nr-1) mod 0x11b: the rcon of the first step of a reverse run
  localparam logic [7:0] RCON_DEC_START_128 = 8'h36;
  localparam logic [7:0] RCON_DEC_START_192 = 8'hd8;
  localparam logic [7:0] RCON_DEC_START_256 = 8'h4d;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    logic [7:0] t;
    t = a[0] ? (a ^ 8'h1b) : a;
    return {a[0], t[7:1]};
  endfunction

endpackage

// File: rtl/rcon_step.sv
// rtl/rcon_step.sv - one forward (x) or reverse (x^-1) round-constant step in GF(2^8)
module rcon_step
  import aes_pkg::*;
(
  input  logic [7:0] i_rcon,
  input  logic [3:0] i_rnd_idx,
  input  logic       i_decrypt,
  output logic [7:0] o_rcon_next
);

  logic [7:0] w_fwd;
  logic [7:0] w_rev;

  // rcon is 0x00 at r=0, so both directions special-case the step touching r=0
  assign w_fwd = (i_rnd_idx == 4'd0) ? 8'h01 : xtime(i_rcon);
  assign w_rev = (i_rnd_idx == 4'd1) ? 8'h00 : inv_xtime(i_rcon);

  assign o_rcon_next = i_decrypt ? w_rev : w_fwd;

endmodule

// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - AES-128/192/256 round sequencer with round index, first/final flags and rcon
module aes_round_seq
  import aes_pkg::*;
#(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_key_len,
  input  logic       i_decrypt,
  input  logic       i_adv,
  output logic       o_busy,
  output logic [3:0] o_rnd_idx,
  output logic       o_first_rnd,
  output logic       o_final_rnd,
  output logic [7:0] o_rcon,
  output logic       o_done,
  output logic       o_err
);

  state_e     r_state;
  logic [3:0] r_nr;
  logic       r_dec;
  logic       r_busy;
  logic [3:0] r_rnd_idx;
  logic       r_first;
  logic       r_final;
  logic [7:0] r_rcon;
  logic       r_done;
  logic       r_err;

  logic       w_key_ok;
  logic [3:0] w_nr;
  logic [7:0] w_rcon_start;
  logic [3:0] w_rnd_next;
  logic [7:0] w_rcon_next;

  always_comb begin
    w_key_ok     = 1'b0;
    w_nr         = NR_128;
    w_rcon_start = RCON_DEC_START_128;
    case (i_key_len)
      KEY_LEN_128: w_key_ok = 1'b1;
      KEY_LEN_192: begin
        w_key_ok     = SUPPORT_192;
        w_nr         = NR_192;
        w_rcon_start = RCON_DEC_START_192;
      end
      KEY_LEN_256: begin
        w_key_ok     = SUPPORT_256;
        w_nr         = NR_256;
        w_rcon_start = RCON_DEC_START_256;
      end
      default: w_key_ok = 1'b0;
    endcase
  end

  assign w_rnd_next = r_dec ? (r_rnd_idx - 4'd1) : (r_rnd_idx + 4'd1);

  rcon_step u_rcon_step (
    .i_rcon      (r_rcon),
    .i_rnd_idx   (r_rnd_idx),
    .i_decrypt   (r_dec),
    .o_rcon_next (w_rcon_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_nr      <= NR_128;
      r_dec     <= 1'b0;
      r_busy    <= 1'b0;
      r_rnd_idx <= 4'd0;
      r_first   <= 1'b0;
      r_final   <= 1'b0;
      r_rcon    <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_key_ok) begin
              r_state   <= ST_RUN;
              r_nr      <= w_nr;
              r_dec     <= i_decrypt;
              r_busy    <= 1'b1;
              r_first   <= 1'b1;
              r_final   <= 1'b0;
              r_rnd_idx <= i_decrypt ? w_nr : 4'd0;
              r_rcon    <= i_decrypt ? w_rcon_start : 8'h00;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_adv) begin
            if (r_final) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_rnd_idx <= 4'd0;
              r_rcon    <= 8'h00;
              r_first   <= 1'b0;
              r_final   <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_rnd_idx <= w_rnd_next;
              r_rcon    <= w_rcon_next;
              r_first   <= 1'b0;
              r_final   <= r_dec ? (w_rnd_next == 4'd0) : (w_rnd_next == r_nr);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_rnd_idx   = r_rnd_idx;
  assign o_first_rnd = r_first;
  assign o_final_rnd = r_final;
  assign o_rcon      = r_rcon;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - directed self-checking bench for aes_round_seq
module tb_aes_round_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] key_len;
  logic       decrypt;
  logic       adv;

  logic       busy, first_rnd, final_rnd, done, err;
  logic [3:0] rnd_idx;
  logic [7:0] rcon;
  logic       busy2, first2, final2, done2, err2;
  logic [3:0] rnd_idx2;
  logic [7:0] rcon2;

  int n_tests = 0;
  int n_fail  = 0;

  // rcon expected for round index r: x^(r-1) mod 0x11b, 0x00 at r=0
  logic [7:0] rcon_tbl [0:14] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

  always #5 clk = ~clk;

  aes_round_seq u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key_len(key_len), .i_decrypt(decrypt),
    .i_adv(adv), .o_busy(busy), .o_rnd_idx(rnd_idx), .o_first_rnd(first_rnd),
    .o_final_rnd(final_rnd), .o_rcon(rcon), .o_done(done), .o_err(err)
  );

  aes_round_seq #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) u_dut_no256 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key_len(key_len), .i_decrypt(decrypt),
    .i_adv(adv), .o_busy(busy2), .o_rnd_idx(rnd_idx2), .o_first_rnd(first2),
    .o_final_rnd(final2), .o_rcon(rcon2), .o_done(done2), .o_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " idx"}, 32'(rnd_idx), 32'd0);
    check({tag, " rcon"}, 32'(rcon), 32'h00);
    check({tag, " first"}, 32'(first_rnd), 32'd0);
    check({tag, " final"}, 32'(final_rnd), 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [1:0] kl, input logic dec,
                           input int nr, input bit toggle, input bit mid_start);
    int r;
    start = 1'b1; key_len = kl; decrypt = dec; adv = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 0; k <= nr; k++) begin
      r = dec ? nr - k : k;
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " idx"}, 32'(rnd_idx), 32'(r));
      check({tag, " rcon"}, 32'(rcon), 32'(rcon_tbl[r]));
      check({tag, " first"}, 32'(first_rnd), 32'(k == 0));
      check({tag, " final"}, 32'(final_rnd), 32'(k == nr));
      if (toggle) begin
        adv = 1'b0;
        cyc();
        check({tag, " hold idx"}, 32'(rnd_idx), 32'(r));
        check({tag, " hold rcon"}, 32'(rcon), 32'(rcon_tbl[r]));
      end
      if (mid_start && k == 3) begin
        start = 1'b1; key_len = 2'd0; decrypt = ~dec; adv = 1'b0;
        cyc();
        start = 1'b0; decrypt = dec;
        check({tag, " busy start ignored idx"}, 32'(rnd_idx), 32'(r));
        check({tag, " busy start no err"}, 32'(err), 32'd0);
      end
      adv = 1'b1;
      cyc();
      adv = 1'b0;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check_idle({tag, " end"});
    cyc();
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'd0; decrypt = 1'b0; adv = 1'b0;
    cyc();
    cyc();
    check_idle("reset");
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    run_check("enc128", 2'd0, 1'b0, 10, 1'b0, 1'b0);
    run_check("dec256", 2'd2, 1'b1, 14, 1'b0, 1'b1);
    run_check("enc192", 2'd1, 1'b0, 12, 1'b1, 1'b0);

    // illegal key length is rejected with a single err pulse
    start = 1'b1; key_len = 2'd3; decrypt = 1'b0; adv = 1'b1;
    cyc();
    start = 1'b0; adv = 1'b0;
    check("kl3 err", 32'(err), 32'd1);
    check("kl3 busy", 32'(busy), 32'd0);
    cyc();
    check("kl3 err pulse", 32'(err), 32'd0);

    // key_len=2 rejected only by the instance built without AES-256
    start = 1'b1; key_len = 2'd2; decrypt = 1'b0;
    cyc();
    start = 1'b0;
    check("no256 err", 32'(err2), 32'd1);
    check("no256 busy", 32'(busy2), 32'd0);
    check("with256 busy", 32'(busy), 32'd1);
    check("with256 err", 32'(err), 32'd0);
    cyc();
    check("no256 err pulse", 32'(err2), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // reset mid-run at r=5 abandons the run without done
    start = 1'b1; key_len = 2'd0; decrypt = 1'b0;
    cyc();
    start = 1'b0;
    adv = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    adv = 1'b0;
    check("mid idx5", 32'(rnd_idx), 32'd5);
    check("mid rcon", 32'(rcon), 32'h10);
    rst = 1'b1; adv = 1'b1;
    cyc();
    rst = 1'b0; adv = 1'b0;
    check_idle("rst mid");
    check("rst mid done", 32'(done), 32'd0);
    run_check("post rst enc128", 2'd0, 1'b0, 10, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
